mem_stage: RTL and testbench

Memory-access stage of the five-stage RV32I pipeline, sitting between the EX/MEM pipeline register and MEM/WB. It decodes loads and stores from the forwarded instruction, drives the data-RAM request/grant/rvalid bus with byte enables, and aligns and sign-extends load data. It stalls the front of the pipe through `hold_flag_o` while an access is outstanding, then registers the write-back fields for WB.

---
 rtl/mem_stage_pkg.sv | 31 +++
 rtl/mem_lsu_align.sv | 60 ++++++
 rtl/mem_stage.sv | 183 ++++++++++++++++++
 tb/tb_mem_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory stage: RV32I load/store opcodes and funct3 codes,
// data-bus geometry and the access FSM state encoding.
package mem_stage_pkg;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam int BUS_W     = 32;
    localparam int BUS_LANES = 4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_WAIT_R = 2'd2
    } mem_state_e;

    function automatic logic is_load_f3(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
    endfunction

    function automatic logic is_store_f3(input logic [2:0] f3);
        return f3 inside {F3_B, F3_H, F3_W};
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Byte-lane logic for the memory stage: byte enables, store-data replication and
// load-data extraction with sign/zero extension.
module mem_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]           funct3,
    input  logic [1:0]           addr_lo,
    input  logic [BUS_W-1:0]     store_data,
    input  logic [BUS_W-1:0]     load_raw,
    output logic [BUS_LANES-1:0] byte_en,
    output logic [BUS_W-1:0]     store_lanes,
    output logic [BUS_W-1:0]     load_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        ld_byte = load_raw[7:0];
        case (addr_lo)
            2'd1:    ld_byte = load_raw[15:8];
            2'd2:    ld_byte = load_raw[23:16];
            2'd3:    ld_byte = load_raw[31:24];
            default: ld_byte = load_raw[7:0];
        endcase
        // Halfword lane ignores a[0]; word ignores both bits (aligned down).
        ld_half = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    end

    always_comb begin
        byte_en     = '0;
        store_lanes = store_data;
        load_data   = load_raw;
        case (funct3)
            F3_B: begin
                byte_en     = 4'b0001 << addr_lo;
                store_lanes = {4{store_data[7:0]}};
                load_data   = {{24{ld_byte[7]}}, ld_byte};
            end
            F3_H: begin
                byte_en     = addr_lo[1] ? 4'b1100 : 4'b0011;
                store_lanes = {2{store_data[15:0]}};
                load_data   = {{16{ld_half[15]}}, ld_half};
            end
            F3_W: begin
                byte_en = 4'b1111;
            end
            F3_BU: begin
                byte_en   = 4'b0001 << addr_lo;
                load_data = {24'd0, ld_byte};
            end
            F3_HU: begin
                byte_en   = addr_lo[1] ? 4'b1100 : 4'b0011;
                load_data = {16'd0, ld_half};
            end
            default: byte_en = '0;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: load/store FSM on a req/gnt/rvalid data bus, WB registers.
// Define MEM_MISALIGN_TRAP_EN to trap misaligned halfword/word accesses via misalign_o.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_100M,
    input  logic              arst_n,
    input  logic              clear,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       reg_waddr_i,
    input  logic              reg_w_ena_i,
    input  logic [31:0]       reg_w_data_i,
    input  logic [ADDR_W-1:0] ram_waddr_i,
    input  logic [DATA_W-1:0] ram_wdata_i,
    output logic              dmem_req_o,
    output logic              dmem_we_o,
    output logic [3:0]        dmem_be_o,
    output logic [ADDR_W-1:0] dmem_addr_o,
    output logic [DATA_W-1:0] dmem_wdata_o,
    input  logic              dmem_gnt_i,
    input  logic              dmem_rvalid_i,
    input  logic [DATA_W-1:0] dmem_rdata_i,
    output logic [31:0]       reg_waddr_o,
    output logic              reg_w_ena_o,
    output logic [31:0]       reg_w_data_o,
    output logic              valid_o,
    output logic              hold_flag_o
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic              misalign_o
`endif
);

    mem_state_e  state, state_n;
    logic        drop, drop_n;
    logic        req, done, pass;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_load, is_store, mem_op, misalign;
    logic [3:0]  byte_en;
    logic [31:0] store_lanes, load_data;
    logic        unused_inst;

    assign opcode      = inst_i[6:0];
    assign funct3      = inst_i[14:12];
    assign is_load     = (opcode == OPC_LOAD)  && is_load_f3(funct3);
    assign is_store    = (opcode == OPC_STORE) && is_store_f3(funct3);
    assign mem_op      = is_load || is_store;
    assign unused_inst = ^{inst_i[31:15], inst_i[11:7]};

`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign = mem_op &&
                      (((funct3[1:0] == 2'b01) && ram_waddr_i[0]) ||
                       ((funct3[1:0] == 2'b10) && (ram_waddr_i[1:0] != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    mem_lsu_align u_align (
        .funct3      (funct3),
        .addr_lo     (ram_waddr_i[1:0]),
        .store_data  (ram_wdata_i),
        .load_raw    (dmem_rdata_i),
        .byte_en     (byte_en),
        .store_lanes (store_lanes),
        .load_data   (load_data)
    );

    // clear withdraws any request not yet granted, so the slave never sees a
    // flushed access; only an rvalid already owed can arrive later (drop flag).
    always_comb begin
        state_n = state;
        drop_n  = drop;
        req     = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (drop && dmem_rvalid_i) begin
                    drop_n = 1'b0;
                end
                if (clear) begin
                    state_n = ST_IDLE;
                end else if (!mem_op) begin
                    pass = 1'b1;
                end else if (misalign) begin
                    done = 1'b1;
                end else if (!drop) begin
                    req = 1'b1;
                    if (!dmem_gnt_i) begin
                        state_n = ST_REQ;
                    end else if (is_store) begin
                        done = 1'b1;
                    end else begin
                        state_n = ST_WAIT_R;
                    end
                end
            end
            ST_REQ: begin
                if (clear) begin
                    state_n = ST_IDLE;
                end else begin
                    req = 1'b1;
                    if (dmem_gnt_i) begin
                        if (is_store) begin
                            done    = 1'b1;
                            state_n = ST_IDLE;
                        end else begin
                            state_n = ST_WAIT_R;
                        end
                    end
                end
            end
            ST_WAIT_R: begin
                if (clear) begin
                    state_n = ST_IDLE;
                    drop_n  = !dmem_rvalid_i;
                end else if (dmem_rvalid_i) begin
                    done    = 1'b1;
                    state_n = ST_IDLE;
                end
            end
            default: begin
                state_n = ST_IDLE;
                drop_n  = 1'b0;
            end
        endcase
    end

    assign dmem_req_o   = req;
    assign dmem_we_o    = req && is_store;
    assign dmem_be_o    = req ? byte_en : 4'b0000;
    assign dmem_addr_o  = {ram_waddr_i[ADDR_W-1:2], 2'b00};
    assign dmem_wdata_o = store_lanes;
    assign hold_flag_o  = mem_op && !misalign && !done;

    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            state <= ST_IDLE;
            drop  <= 1'b0;
        end else begin
            state <= state_n;
            drop  <= drop_n;
        end
    end

    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            reg_waddr_o  <= '0;
            reg_w_ena_o  <= 1'b0;
            reg_w_data_o <= '0;
            valid_o      <= 1'b0;
        end else if (clear) begin
            valid_o <= 1'b0;
        end else if (done) begin
            reg_waddr_o  <= reg_waddr_i;
            reg_w_ena_o  <= is_load && !misalign && reg_w_ena_i;
            reg_w_data_o <= (is_load && !misalign) ? load_data : reg_w_data_i;
            valid_o      <= 1'b1;
        end else if (pass) begin
            reg_waddr_o  <= reg_waddr_i;
            reg_w_ena_o  <= reg_w_ena_i;
            reg_w_data_o <= reg_w_data_i;
            valid_o      <= 1'b1;
        end else begin
            valid_o <= 1'b0;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk_100M or negedge arst_n) begin
        if (!arst_n) begin
            misalign_o <= 1'b0;
        end else begin
            misalign_o <= !clear && done && misalign;
        end
    end
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed load/store/pass-through/clear vectors
// against a byte-lane arithmetic model, checked every cycle on the falling edge.
module tb_mem_stage;

    logic        clk_100M;
    logic        arst_n;
    logic        clear;
    logic [31:0] inst_i;
    logic [31:0] reg_waddr_i;
    logic        reg_w_ena_i;
    logic [31:0] reg_w_data_i;
    logic [31:0] ram_waddr_i;
    logic [31:0] ram_wdata_i;
    logic        dmem_req_o;
    logic        dmem_we_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_addr_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_gnt_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [31:0] reg_waddr_o;
    logic        reg_w_ena_o;
    logic [31:0] reg_w_data_o;
    logic        valid_o;
    logic        hold_flag_o;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_o;
`endif

    mem_stage dut (
        .clk_100M      (clk_100M),
        .arst_n        (arst_n),
        .clear         (clear),
        .inst_i        (inst_i),
        .reg_waddr_i   (reg_waddr_i),
        .reg_w_ena_i   (reg_w_ena_i),
        .reg_w_data_i  (reg_w_data_i),
        .ram_waddr_i   (ram_waddr_i),
        .ram_wdata_i   (ram_wdata_i),
        .dmem_req_o    (dmem_req_o),
        .dmem_we_o     (dmem_we_o),
        .dmem_be_o     (dmem_be_o),
        .dmem_addr_o   (dmem_addr_o),
        .dmem_wdata_o  (dmem_wdata_o),
        .dmem_gnt_i    (dmem_gnt_i),
        .dmem_rvalid_i (dmem_rvalid_i),
        .dmem_rdata_i  (dmem_rdata_i),
        .reg_waddr_o   (reg_waddr_o),
        .reg_w_ena_o   (reg_w_ena_o),
        .reg_w_data_o  (reg_w_data_o),
        .valid_o       (valid_o),
        .hold_flag_o   (hold_flag_o)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misalign_o    (misalign_o)
`endif
    );

    initial clk_100M = 1'b0;
    always #5 clk_100M = ~clk_100M;

    int n_cmp  = 0;
    int n_fail = 0;

    // Expectations for the current cycle and WB fields due at the next edge.
    logic        chk_en = 1'b0;
    logic        exp_req, exp_hold, exp_valid, exp_we, exp_wb_ena, exp_dchk, exp_mis;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr, exp_wdata, exp_wb_addr, exp_wb_data;
    logic        nxt_valid = 1'b0, nxt_ena = 1'b0, nxt_dchk = 1'b0, nxt_mis = 1'b0;
    logic [31:0] nxt_addr = '0, nxt_data = '0;

    // Observation history from the compare process.
    int          req_cnt = 0, hold_cnt = 0, val_cnt = 0;
    logic [3:0]  last_be = '0;
    logic        last_we = 1'b0, last_wb_ena = 1'b0;
    logic [31:0] last_bus_addr = '0, last_wdata = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic int unsigned sz(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic int unsigned lane(input logic [2:0] f3, input logic [31:0] a);
        int unsigned l;
        l = a[1:0];
        return l - (l % sz(f3));
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] t;
        t = ((32'd1 << sz(f3)) - 32'd1) << lane(f3, a);
        return t[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (sz(f3))
            1:       return {24'd0, d[7:0]} * 32'h0101_0101;
            2:       return {16'd0, d[15:0]} * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] raw);
        int unsigned s;
        logic [31:0] mask, v;
        s    = sz(f3);
        mask = (s == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * s)) - 32'd1);
        v    = (raw >> (8 * lane(f3, a))) & mask;
        if (!f3[2] && s < 4 && v[8 * s - 1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- compare process ----------------
    initial forever begin
        @(negedge clk_100M);
        if (chk_en) begin
            chk("req", {31'd0, dmem_req_o}, {31'd0, exp_req});
            chk("hold", {31'd0, hold_flag_o}, {31'd0, exp_hold});
            chk("valid", {31'd0, valid_o}, {31'd0, exp_valid});
            if (exp_req) begin
                chk("bus_addr", dmem_addr_o, exp_addr);
                chk("bus_be", {28'd0, dmem_be_o}, {28'd0, exp_be});
                chk("bus_we", {31'd0, dmem_we_o}, {31'd0, exp_we});
                if (exp_we) chk("bus_wdata", dmem_wdata_o, exp_wdata);
            end
            if (exp_valid) begin
                chk("wb_addr", reg_waddr_o, exp_wb_addr);
                chk("wb_ena", {31'd0, reg_w_ena_o}, {31'd0, exp_wb_ena});
                if (exp_dchk) chk("wb_data", reg_w_data_o, exp_wb_data);
            end
`ifdef MEM_MISALIGN_TRAP_EN
            chk("misalign", {31'd0, misalign_o}, {31'd0, exp_mis});
`endif
            if (dmem_req_o) begin
                req_cnt++;
                last_be       = dmem_be_o;
                last_we       = dmem_we_o;
                last_bus_addr = dmem_addr_o;
                last_wdata    = dmem_wdata_o;
            end
            if (hold_flag_o) hold_cnt++;
            if (valid_o) begin
                val_cnt++;
                last_wb_ena = reg_w_ena_o;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_100M);
        #1;
        exp_valid   = nxt_valid;
        exp_wb_addr = nxt_addr;
        exp_wb_ena  = nxt_ena;
        exp_wb_data = nxt_data;
        exp_dchk    = nxt_dchk;
        exp_mis     = nxt_mis;
        nxt_valid   = 1'b0;
        nxt_mis     = 1'b0;
        clear         = 1'b0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h5A5A_5A5A;
        exp_req       = 1'b0;
        exp_hold      = 1'b0;
    endtask

    task automatic complete(input logic [31:0] rd, input logic ena, input logic [31:0] data,
                            input logic dchk);
        nxt_valid = 1'b1;
        nxt_addr  = rd;
        nxt_ena   = ena;
        nxt_data  = data;
        nxt_dchk  = dchk;
    endtask

    task automatic pass_op(input logic [31:0] inst, input logic [31:0] rd, input logic ena,
                           input logic [31:0] data);
        step();
        inst_i       = inst;
        reg_waddr_i  = rd;
        reg_w_ena_i  = ena;
        reg_w_data_i = data;
        complete(rd, ena, data, 1'b1);
    endtask

    task automatic idle();
        pass_op(32'h0000_0013, 32'd0, 1'b0, 32'd0);
    endtask

    task automatic set_mem(input logic [31:0] inst, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rd);
        inst_i       = inst;
        ram_waddr_i  = addr;
        ram_wdata_i  = wd;
        reg_waddr_i  = rd;
        reg_w_ena_i  = 1'b1;
        reg_w_data_i = 32'hCAFE_0000;
        exp_addr     = addr & ~32'd3;
        exp_be       = m_be(inst[14:12], addr);
        exp_we       = (inst[6:0] == 7'b0100011);
        exp_wdata    = m_wdata(inst[14:12], wd);
    endtask

    task automatic mem_op(input logic [31:0] inst, input logic [31:0] addr, input logic [31:0] wd,
                          input logic [31:0] rdata, input int gnt_dly, input int rv_dly,
                          input logic [31:0] rd);
        logic st;
        st = (inst[6:0] == 7'b0100011);
`ifdef MEM_MISALIGN_TRAP_EN
        if ((addr[1:0] % sz(inst[14:12])) != 0) begin
            step();
            set_mem(inst, addr, wd, rd);
            complete(rd, 1'b0, 32'd0, 1'b0);
            nxt_mis = 1'b1;
            return;
        end
`endif
        for (int c = 0; c <= gnt_dly; c++) begin
            step();
            set_mem(inst, addr, wd, rd);
            dmem_gnt_i = (c == gnt_dly);
            exp_req    = 1'b1;
            if (st && c == gnt_dly) complete(rd, 1'b0, 32'd0, 1'b0);
            else exp_hold = 1'b1;
        end
        if (!st) begin
            for (int c = 1; c <= rv_dly; c++) begin
                step();
                if (c == rv_dly) begin
                    dmem_rvalid_i = 1'b1;
                    dmem_rdata_i  = rdata;
                    complete(rd, 1'b1, m_load(inst[14:12], addr, rdata), 1'b1);
                end else begin
                    exp_hold = 1'b1;
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk_100M);
        #1;
    endtask

    // ---------------- directed sequence ----------------
    int b_req, b_hold, b_val;

    initial begin
        arst_n        = 1'b0;
        clear         = 1'b0;
        inst_i        = 32'h0000_0013;
        reg_waddr_i   = '0;
        reg_w_ena_i   = 1'b0;
        reg_w_data_i  = '0;
        ram_waddr_i   = '0;
        ram_wdata_i   = '0;
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = '0;
        #12;
        chk("rst_req", {31'd0, dmem_req_o}, 32'd0);
        chk("rst_hold", {31'd0, hold_flag_o}, 32'd0);
        chk("rst_valid", {31'd0, valid_o}, 32'd0);
        chk("rst_wb_data", reg_w_data_o, 32'd0);
        chk("rst_wb_addr", reg_waddr_o, 32'd0);
        chk("rst_wb_ena", {31'd0, reg_w_ena_o}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
        chk("rst_misalign", {31'd0, misalign_o}, 32'd0);
`endif
        #10;
        arst_n = 1'b1;
        complete(32'd0, 1'b0, 32'd0, 1'b1);
        chk_en = 1'b1;
        idle();
        idle();

        // ADD pass-through
        pass_op(32'h0020_81B3, 32'd5, 1'b1, 32'h0000_1234);
        b_req = req_cnt;
        idle();
        settle();
        chk("add_data", reg_w_data_o, 32'h0000_1234);
        chk("add_rd", reg_waddr_o, 32'd5);
        chk("add_valid", {31'd0, valid_o}, 32'd1);
        chk("add_no_req", req_cnt - b_req, 0);

        // SW immediate grant
        b_req = req_cnt; b_hold = hold_cnt; b_val = val_cnt;
        mem_op(32'h0000_2023, 32'h100, 32'hDEAD_BEEF, 32'd0, 0, 0, 32'd0);
        idle();
        settle();
        chk("sw_be", {28'd0, last_be}, 32'hF);
        chk("sw_we", {31'd0, last_we}, 32'd1);
        chk("sw_wdata", last_wdata, 32'hDEAD_BEEF);
        chk("sw_hold_cycles", hold_cnt - b_hold, 0);
        chk("sw_req_cycles", req_cnt - b_req, 1);
        chk("sw_wb_ena", {31'd0, last_wb_ena}, 32'd0);
        chk("sw_valid_cycles", val_cnt - b_val, 2);

        // Load extraction / extension
        mem_op(32'h0000_0003, 32'h103, 32'd0, 32'h80FF_0000, 0, 1, 32'd10);
        idle(); settle();
        chk("lb_data", reg_w_data_o, 32'hFFFF_FF80);
        mem_op(32'h0000_4003, 32'h103, 32'd0, 32'h80FF_0000, 0, 1, 32'd11);
        idle(); settle();
        chk("lbu_data", reg_w_data_o, 32'h0000_0080);
        mem_op(32'h0000_5003, 32'h102, 32'd0, 32'h80FF_0000, 0, 1, 32'd12);
        idle(); settle();
        chk("lhu_data", reg_w_data_o, 32'h0000_80FF);
        mem_op(32'h0000_1003, 32'h102, 32'd0, 32'h80FF_0000, 1, 2, 32'd13);
        idle(); settle();
        chk("lh_data", reg_w_data_o, 32'hFFFF_80FF);

        // SB lane 2, then SH at an odd address
        mem_op(32'h0000_0023, 32'h102, 32'h0000_00AB, 32'd0, 0, 0, 32'd0);
        idle(); settle();
        chk("sb_be", {28'd0, last_be}, 32'h4);
        chk("sb_wdata", last_wdata, 32'hABAB_ABAB);
        b_req = req_cnt;
        mem_op(32'h0000_1023, 32'h201, 32'h1234_CDEF, 32'd0, 0, 0, 32'd0);
        idle();
`ifdef MEM_MISALIGN_TRAP_EN
        settle();
        chk("sh_mis_no_req", req_cnt - b_req, 0);
`else
        settle();
        chk("sh_be", {28'd0, last_be}, 32'h3);
        chk("sh_addr", last_bus_addr, 32'h200);
        chk("sh_wdata", last_wdata, 32'hCDEF_CDEF);
`endif

        // LW: gnt after 3 waiting cycles, rvalid 3 cycles after gnt
        b_req = req_cnt; b_hold = hold_cnt; b_val = val_cnt;
        mem_op(32'h0000_2003, 32'h108, 32'd0, 32'h1357_9BDF, 3, 3, 32'd14);
        idle();
        settle();
        chk("lw_req_cycles", req_cnt - b_req, 4);
        chk("lw_hold_cycles", hold_cnt - b_hold, 6);
        chk("lw_valid_cycles", val_cnt - b_val, 2);
        chk("lw_data", reg_w_data_o, 32'h1357_9BDF);

        // clear in WAIT_R: stale rvalid swallowed, next LW waits for it
        b_req = req_cnt;
        step(); set_mem(32'h0000_2003, 32'h300, 32'd0, 32'd7);
        dmem_gnt_i = 1'b1; exp_req = 1'b1; exp_hold = 1'b1;
        step(); clear = 1'b1; exp_hold = 1'b1;
        step(); set_mem(32'h0000_2003, 32'h304, 32'd0, 32'd8); exp_hold = 1'b1;
        step(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h1111_1111; exp_hold = 1'b1;
        step(); dmem_gnt_i = 1'b1; exp_req = 1'b1; exp_hold = 1'b1;
        step(); dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'h2222_2222;
        complete(32'd8, 1'b1, 32'h2222_2222, 1'b1);
        idle();
        settle();
        chk("clr_wait_data", reg_w_data_o, 32'h2222_2222);
        chk("clr_wait_rd", reg_waddr_o, 32'd8);
        chk("clr_wait_reqs", req_cnt - b_req, 2);

        // clear in REQ withdraws the request; FSM must be back in IDLE
        step(); set_mem(32'h0000_2003, 32'h400, 32'd0, 32'd9); exp_req = 1'b1; exp_hold = 1'b1;
        step(); clear = 1'b1; exp_hold = 1'b1;
        idle();
        mem_op(32'h0000_2023, 32'h404, 32'h0BAD_F00D, 32'd0, 0, 0, 32'd3);
        idle();
        settle();
        chk("clr_req_sw_addr", last_bus_addr, 32'h404);

        idle();
        idle();
        settle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
